// File: rtl/f32_pkg.sv
// ============================================================================
// Module   : f32_pkg
// Brief    : Shared binary32 constants and divider FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package f32_pkg;

    localparam int          F32_BIAS    = 127;
    localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;
    localparam int          F32_EXP_MAX = 255;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_DIVIDE    = 3'd2,
        S_NORMALIZE = 3'd3,
        S_DONE      = 3'd4
    } f32_div_state_t;

endpackage

`default_nettype wire

// File: rtl/f32_classify.sv
// ============================================================================
// Module   : f32_classify
// Brief    : Combinational binary32 operand field split and class decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f32_classify (
    input  logic [31:0] i_op,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] sig,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_denormal
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_nz;

    assign w_exp_zero  = (i_op[30:23] == 8'h00);
    assign w_exp_ones  = (i_op[30:23] == 8'hFF);
    assign w_frac_nz   = |i_op[22:0];

    assign sign        = i_op[31];
    assign exp         = i_op[30:23];
    assign sig         = {~w_exp_zero, i_op[22:0]};
    assign is_zero     = w_exp_zero & ~w_frac_nz;
    assign is_denormal = w_exp_zero &  w_frac_nz;
    assign is_inf      = w_exp_ones & ~w_frac_nz;
    assign is_nan      = w_exp_ones &  w_frac_nz;

endmodule

`default_nettype wire

// File: rtl/f32_div.sv
// ============================================================================
// Module   : f32_div
// Brief    : Multi-cycle binary32 divider, restoring radix-2, truncating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f32_div
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        div_by_zero_o,
    output logic        invalid_o
);

    // The 25th quotient bit is resolved in NORMALIZE, so DIVIDE itself runs 24 cycles.
    localparam logic [4:0]        c_div_last = 5'd23;
    localparam logic signed [9:0] c_bias     = 10'(F32_BIAS);
    localparam logic signed [9:0] c_exp_max  = 10'(F32_EXP_MAX);

    f32_div_state_t r_state, w_state_nxt;

    logic [31:0]        r_a, r_b, r_q;
    logic               r_sign, r_ovf, r_unf, r_dz, r_inv;
    logic signed [9:0]  r_exp;
    logic [23:0]        r_mb, r_quot;
    logic [24:0]        r_rem;
    logic [4:0]         r_cnt;

    logic               w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_da, w_db;
    logic [7:0]         w_ea, w_eb;
    logic [23:0]        w_ma, w_mb;
    logic               w_sign, w_a_zero, w_b_zero, w_special;
    logic [31:0]        w_sp_q;
    logic               w_sp_dz, w_sp_inv;
    logic               w_qbit;
    logic [24:0]        w_rem_sel, w_rem_nxt, w_full;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_mant;

    f32_classify u_cls_a (
        .i_op(r_a), .sign(w_sa), .exp(w_ea), .sig(w_ma),
        .is_zero(w_za), .is_inf(w_ia), .is_nan(w_na), .is_denormal(w_da)
    );

    f32_classify u_cls_b (
        .i_op(r_b), .sign(w_sb), .exp(w_eb), .sig(w_mb),
        .is_zero(w_zb), .is_inf(w_ib), .is_nan(w_nb), .is_denormal(w_db)
    );

    assign w_sign    = w_sa ^ w_sb;
    assign w_a_zero  = w_za | w_da;
    assign w_b_zero  = w_zb | w_db;
    assign w_special = w_na | w_nb | w_ia | w_ib | w_a_zero | w_b_zero;

    always_comb begin
        w_sp_q   = {w_sign, 31'd0};
        w_sp_dz  = 1'b0;
        w_sp_inv = 1'b0;
        if (w_na | w_nb | (w_a_zero & w_b_zero) | (w_ia & w_ib)) begin
            w_sp_q   = F32_QNAN;
            w_sp_inv = 1'b1;
        end else if (w_ia) begin
            w_sp_q = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_sp_q  = {w_sign, 8'hFF, 23'd0};
            w_sp_dz = 1'b1;
        end
    end

    // One restoring step; also supplies the final bit while in NORMALIZE.
    assign w_qbit    = (r_rem >= {1'b0, r_mb});
    assign w_rem_sel = w_qbit ? (r_rem - {1'b0, r_mb}) : r_rem;
    assign w_rem_nxt = w_rem_sel << 1;

    assign w_full    = {r_quot, w_qbit};
    assign w_exp_n   = r_exp + c_bias - $signed({9'd0, ~w_full[24]});
    assign w_mant    = w_full[24] ? w_full[23:1] : w_full[22:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_UNPACK;
            S_UNPACK:    w_state_nxt = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE:    if (r_cnt == c_div_last) w_state_nxt = S_NORMALIZE;
            S_NORMALIZE: w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_q     <= 32'd0;
            r_sign  <= 1'b0;
            r_exp   <= 10'sd0;
            r_mb    <= 24'd0;
            r_quot  <= 24'd0;
            r_rem   <= 25'd0;
            r_cnt   <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_dz    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb});
                    r_mb   <= w_mb;
                    r_rem  <= {1'b0, w_ma};
                    r_quot <= 24'd0;
                    r_cnt  <= 5'd0;
                    if (w_special) begin
                        r_q   <= w_sp_q;
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                        r_dz  <= w_sp_dz;
                        r_inv <= w_sp_inv;
                    end
                end
                S_DIVIDE: begin
                    r_quot <= {r_quot[22:0], w_qbit};
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt + 5'd1;
                end
                S_NORMALIZE: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_dz  <= 1'b0;
                    r_inv <= 1'b0;
                    if (w_exp_n >= c_exp_max) begin
                        r_q   <= {r_sign, 8'hFF, 23'd0};
                        r_ovf <= 1'b1;
                        r_unf <= 1'b0;
                    end else if (w_exp_n <= 10'sd0) begin
                        r_q   <= {r_sign, 31'd0};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b1;
                    end else begin
                        r_q   <= {r_sign, w_exp_n[7:0], w_mant};
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign q             = r_q;
    assign overflow_o    = r_ovf;
    assign underflow_o   = r_unf;
    assign div_by_zero_o = r_dz;
    assign invalid_o     = r_inv;

endmodule

`default_nettype wire

// File: tb/tb_f32_div.sv
// ============================================================================
// Module   : tb_f32_div
// Brief    : Directed self-checking bench for f32_div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f32_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] q;
    logic        overflow_o, underflow_o, div_by_zero_o, invalid_o;

    int n_checks = 0;
    int n_fail   = 0;

    f32_div dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q),
        .overflow_o(overflow_o), .underflow_o(underflow_o),
        .div_by_zero_o(div_by_zero_o), .invalid_o(invalid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle. Flags are {ovf, unf, dz, inv}.
    // poke_at > 0 drives a stray start with other operands after that edge.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [3:0] ef,
                          input int elat, input int poke_at);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 60) begin
            if (n == poke_at) begin
                start = 1'b1;
                a = 32'h3F80_0000;
                b = 32'h4040_0000;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, n, elat);
        check({tag, "_q"}, q, eq);
        check({tag, "_flags"}, {28'd0, overflow_o, underflow_o, div_by_zero_o, invalid_o},
              {28'd0, ef});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_q", q, 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_flags", {28'd0, overflow_o, underflow_o, div_by_zero_o, invalid_o}, 32'd0);
        rst = 1'b0;

        run_op("six_by_two",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0);
        run_op("neg_six",       32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 27, 0);
        run_op("one_third",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 27, 0);
        run_op("one_by_zero",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010, 2,  0);
        run_op("zero_by_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, 2,  0);
        run_op("overflow",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000, 27, 0);
        run_op("underflow",     32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, 27, 0);
        run_op("nan_operand",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001, 2,  0);
        run_op("inf_by_inf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001, 2,  0);
        run_op("neg_inf_by_2",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2,  0);
        run_op("one_by_inf",    32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 2,  0);
        run_op("negzero_by_2",  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 2,  0);
        run_op("denorm_by_1",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 2,  0);
        run_op("start_ignored", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 12);

        // Abort an operation mid-divide; no done may appear while reset is held.
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_done", {31'd0, done}, 32'd0);
        end
        check("abort_q", q, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        run_op("after_abort",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
